fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl.sv | 85 ++++++++
 tb/tb_fifo_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// FIFO controller: drives the write/read pointers of an external register file and
// keeps the occupancy count, threshold flags and sticky error flags registered.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  w_en,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C     = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C     = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic                rd_ok_s;
  logic                wr_ok_s;
  logic                wr_drop_s;
  logic [ADDR_WIDTH:0] count_nxt_s;

  // Accept logic: a write into a full FIFO only goes through alongside an accepted read.
  always_comb begin
    rd_ok_s     = rd & ~empty;
    wr_ok_s     = wr & (~full | rd_ok_s) & ~reset;
    wr_drop_s   = wr & full & ~rd_ok_s;
    count_nxt_s = count;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count + CNT_ONE;
      2'b01:   count_nxt_s = count - CNT_ONE;
      default: count_nxt_s = count;
    endcase
  end

  assign w_en = wr_ok_s;

  // Pointers wrap naturally at DEPTH; flags are derived from the next count so they
  // are coherent with count in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_addr       <= {ADDR_WIDTH{1'b0}};
      r_addr       <= {ADDR_WIDTH{1'b0}};
      count        <= {(ADDR_WIDTH + 1){1'b0}};
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        w_addr <= w_addr + PTR_ONE;
      end
      if (rd_ok_s) begin
        r_addr <= r_addr + PTR_ONE;
      end
      count        <= count_nxt_s;
      full         <= (count_nxt_s == DEPTH_C);
      empty        <= (count_nxt_s == {(ADDR_WIDTH + 1){1'b0}});
      almost_full  <= (count_nxt_s >= AF_C);
      almost_empty <= (count_nxt_s <= AE_C);
      if (wr_drop_s) begin
        overflow <= 1'b1;
      end
      if (rd & empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed testbench for fifo_ctrl; models the external register file locally and
// compares against hand-computed values.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] w_data = 8'd0;
  logic [2:0] w_addr, r_addr;
  logic       w_en, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  logic [7:0] mem [8];
  logic [7:0] r_data;
  logic [7:0] fill_data [8] = '{8'd20, 8'd10, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail = 0;

  fifo_ctrl #(.ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd),
    .w_addr(w_addr), .r_addr(r_addr), .w_en(w_en),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // External register file
  always @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end
  assign r_data = mem[r_addr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr = 1'b0; rd = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; rd = 1'b0; w_data = fill_data[i];
      #1 check_eq("fill_wen", w_en, 1);
      tick();
      check_eq("fill_count", count, i + 1);
      check_eq("fill_af", almost_full, (i + 1 >= 6));
      check_eq("fill_full", full, (i + 1 == 8));
      check_eq("fill_ae", almost_empty, (i + 1 <= 2));
    end
    wr = 1'b0;
    check_eq("fill_waddr_wrap", w_addr, 0);
    check_eq("fill_head", r_data, 20);
  endtask

  initial begin
    // Reset with wr held high: no write may be enabled
    reset = 1'b1; wr = 1'b1; w_data = 8'd55;
    #1 check_eq("rst_wen", w_en, 0);
    tick();
    reset = 1'b0; wr = 1'b0;
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_ae", almost_empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_af", almost_full, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_udf", underflow, 0);
    check_eq("rst_waddr", w_addr, 0);
    check_eq("rst_raddr", r_addr, 0);

    fill();

    // Full plus simultaneous read/write
    wr = 1'b1; rd = 1'b1; w_data = 8'd50;
    #1 check_eq("frw_wen", w_en, 1);
    tick();
    wr = 1'b0; rd = 1'b0;
    check_eq("frw_full", full, 1);
    check_eq("frw_count", count, 8);
    check_eq("frw_ovf", overflow, 0);
    check_eq("frw_raddr", r_addr, 1);
    check_eq("frw_waddr", w_addr, 1);
    check_eq("frw_head", r_data, 10);
    check_eq("frw_tail", mem[0], 50);

    do_reset();
    fill();

    // Overflow
    wr = 1'b1; rd = 1'b0; w_data = 8'd99;
    #1 check_eq("ovf_wen", w_en, 0);
    tick();
    wr = 1'b0;
    check_eq("ovf_count", count, 8);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_waddr", w_addr, 0);
    check_eq("ovf_head", r_data, 20);

    // Drain
    for (int i = 0; i < 8; i++) begin
      rd = 1'b1;
      #1 check_eq("drain_data", r_data, fill_data[i]);
      tick();
      check_eq("drain_count", count, 7 - i);
      check_eq("drain_empty", empty, (i == 7));
    end
    check_eq("drain_ae", almost_empty, 1);
    check_eq("drain_udf_pre", underflow, 0);
    tick();
    rd = 1'b0;
    check_eq("udf_flag", underflow, 1);
    check_eq("udf_count", count, 0);
    check_eq("udf_raddr", r_addr, 0);

    // Empty with simultaneous wr & rd: write only, underflow set
    do_reset();
    wr = 1'b1; rd = 1'b1; w_data = 8'd77;
    #1 check_eq("erw_wen", w_en, 1);
    tick();
    wr = 1'b0; rd = 1'b0;
    check_eq("erw_count", count, 1);
    check_eq("erw_udf", underflow, 1);
    check_eq("erw_empty", empty, 0);
    check_eq("erw_raddr", r_addr, 0);
    check_eq("erw_head", r_data, 77);
    exp_q.push_back(8'd77);

    // Bring count to 3, then stream wr & rd across the pointer wrap
    for (int i = 0; i < 2; i++) begin
      wr = 1'b1; w_data = 8'(31 + i);
      tick();
      exp_q.push_back(w_data);
    end
    wr = 1'b0;
    check_eq("sim_count3", count, 3);
    for (int i = 0; i < 7; i++) begin
      wr = 1'b1; rd = 1'b1; w_data = 8'(41 + i);
      #1 check_eq("sim_data", r_data, exp_q.pop_front());
      tick();
      exp_q.push_back(w_data);
      check_eq("sim_count", count, 3);
    end
    wr = 1'b0; rd = 1'b0;
    check_eq("sim_waddr_wrap", w_addr, 2);
    check_eq("sim_raddr", r_addr, 7);
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1;
      #1 check_eq("sim_tail_data", r_data, exp_q.pop_front());
      tick();
    end
    rd = 1'b0;
    check_eq("sim_empty", empty, 1);

    // Mid-operation reset with count = 5 and overflow set
    do_reset();
    fill();
    wr = 1'b1; w_data = 8'd99;
    tick();
    wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1;
      tick();
    end
    rd = 1'b0;
    check_eq("mid_count5", count, 5);
    check_eq("mid_ovf_set", overflow, 1);
    reset = 1'b1; wr = 1'b1;
    #1 check_eq("mid_wen", w_en, 0);
    tick();
    reset = 1'b0; wr = 1'b0;
    check_eq("mid_count", count, 0);
    check_eq("mid_empty", empty, 1);
    check_eq("mid_ovf", overflow, 0);
    check_eq("mid_waddr", w_addr, 0);
    check_eq("mid_raddr", r_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
